fifo_stream_reader: RTL
=======================

# fifo_stream_reader

Consumer-side adapter for the synchronous FIFO. It pops words through the FIFO read port (`rd_en` / `empty` / registered `data_out`) and presents them on a valid/ready output stream. It absorbs the FIFO's one-cycle read latency with a small internal skid buffer, so the stream sustains one word per cycle under continuous `m_ready`. It sits between the FIFO read side and any downstream consumer, and also counts delivered words and flags protocol errors.

## Interface
- `FIFO_WIDTH`, default 16: data word width; must match the FIFO.
- `BUF_DEPTH`, default 4: skid-buffer entries. Minimum legal value is 2; 3 or more is required for full throughput.
- `CNT_WIDTH`, default 16: width of the delivered-word counter.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  read enable. When low, no new FIFO pops are issued; buffered words still drain.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_data_out`  in  FIFO_WIDTH  FIFO `data_out`; valid in the cycle after an accepted pop.
- `fifo_underflow`  in  1  FIFO `underflow` flag.
- `fifo_rd_en`  out  1  pop request to the FIFO `rd_en`.
- `m_valid`  out  1  output word available.
- `m_data`  out  FIFO_WIDTH  output word (head of the skid buffer).
- `m_ready`  in  1  downstream accepts the word.
- `word_cnt`  out  CNT_WIDTH  number of words delivered (`m_valid && m_ready`), modulo 2^CNT_WIDTH.
- `err_underflow`  out  1  sticky flag: `fifo_underflow` was seen high.

## Operation
- Internal state:
  - circular buffer `mem[BUF_DEPTH]` with head/tail pointers of width $clog2(BUF_DEPTH), wrapping at BUF_DEPTH;
  - `occ` register, range 0..BUF_DEPTH;
  - `inflight` flag register.
- `fifo_rd_en = en && !fifo_empty && (occ + inflight < BUF_DEPTH)`.
  - Combinational from registered state, `en` and `fifo_empty` only.
  - Never depends on `m_ready`.
  - Never asserts while `fifo_empty` is high, so the FIFO never underflows through this block.
- `inflight` next value = `fifo_rd_en`, i.e. a pop was accepted this cycle.
- Capture: when `inflight` is 1, write `fifo_data_out` into `mem[tail]` and increment `tail`.
- Output:
  - `m_valid = (occ != 0)`;
  - `m_data = mem[head]`;
  - on `m_valid && m_ready`, increment `head` and `word_cnt`.
- Occupancy update:
  - capture only: `occ + 1`;
  - pop only: `occ - 1`;
  - capture and pop in the same cycle: `occ` unchanged, tail writes and head reads in the same cycle.
- The credit rule guarantees a capture never arrives when `occ == BUF_DEPTH`. A buffer overrun is therefore a design bug; assert it in simulation.
- `m_data` is stable while `m_valid && !m_ready`, since `head` does not move.
- `en` deasserted mid-stream: the pop already in flight is still captured; the stream drains until `occ` reaches 0.
- `err_underflow` is set on any cycle with `fifo_underflow` high. It is cleared only by `rst`.
- `word_cnt` wraps from 2^CNT_WIDTH-1 to 0 with no flag.

## Timing
- Reset values:
  - `m_valid` 0, `m_data` 0 (mem cleared), `word_cnt` 0, `err_underflow` 0;
  - `fifo_rd_en` 0 (`occ`, `inflight`, pointers all 0).
- Reset asserted mid-operation clears everything asynchronously; an in-flight word is discarded. The first pop may be issued in the first cycle after `rst` is released.
- Latency:
  - `fifo_rd_en` high in cycle N;
  - FIFO `data_out` valid in cycle N+1 and captured at the end of N+1;
  - `m_valid` high in cycle N+2.
- Throughput with `BUF_DEPTH >= 3` and `m_ready` held high: one word per cycle in steady state.
- Throughput with `BUF_DEPTH == 2`: one word every 2 cycles.
- Backpressure (`m_ready` low): `occ` fills to BUF_DEPTH, then `fifo_rd_en` drops. This happens at most BUF_DEPTH words after the stall begins, counting in-flight words.
- FIFO with one word (count 1, so `fifo_empty` is 0): one pop issued. `fifo_empty` rises the next cycle and no further pop is issued.

## Test plan
- Reset, then FIFO preloaded with 0x0001..0x0008, `en`=1, `m_ready`=1 -> first `m_valid` 2 cycles after the first `fifo_rd_en`; 8 consecutive words in order; `word_cnt`=8; `fifo_rd_en` never high while `fifo_empty` is high.
- FIFO holding 8 words, `m_ready`=0 for 10 cycles, then 1 -> `fifo_rd_en` high for exactly 4 cycles, `occ` reaches 4, `m_data` stays 0x0001 during the stall; all 8 words are then delivered in order with no loss or duplicate.
- `m_ready` toggling 1/0 each cycle with 16 words in the FIFO -> order preserved; buffer pointers wrap; `word_cnt`=16.
- `en` dropped one cycle after the first pop -> the in-flight word is still delivered, no further pops are issued, and `m_valid` falls after the buffer drains.
- `rst` pulsed while `occ`=3 and a pop is in flight -> all outputs return to their reset values immediately; after release, normal reads resume from the FIFO's current word.
- `fifo_underflow` forced high for 1 cycle -> `err_underflow`=1 and stays 1 until `rst`; with `CNT_WIDTH`=4, delivering 17 words gives `word_cnt`=1.

Source files
------------

// File: rtl/fifo_stream_reader_if.sv
// Bundles the FIFO read port and the valid/ready output stream of fifo_stream_reader.
// The master side is the reader; the slave side is the FIFO plus downstream consumer.
interface fifo_stream_reader_if #(
  parameter int FIFO_WIDTH = 16
);
  logic                  fifo_rd_en;
  logic                  fifo_empty;
  logic [FIFO_WIDTH-1:0] fifo_data_out;
  logic                  fifo_underflow;
  logic                  m_valid;
  logic                  m_ready;
  logic [FIFO_WIDTH-1:0] m_data;

  modport master (
    output fifo_rd_en,
    output m_valid,
    output m_data,
    input  fifo_empty,
    input  fifo_data_out,
    input  fifo_underflow,
    input  m_ready
  );

  modport slave (
    input  fifo_rd_en,
    input  m_valid,
    input  m_data,
    output fifo_empty,
    output fifo_data_out,
    output fifo_underflow,
    output m_ready
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Pops a synchronous FIFO and re-presents its words on a valid/ready stream, hiding the
// FIFO's one-cycle read latency behind a small credit-controlled skid buffer.
module fifo_stream_reader #(
  parameter int FIFO_WIDTH = 16,
  parameter int BUF_DEPTH  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  fifo_stream_reader_if.master bus,
  output logic [CNT_WIDTH-1:0] word_cnt,
  output logic                 err_underflow
);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(BUF_DEPTH);

  logic [FIFO_WIDTH-1:0] r_mem [BUF_DEPTH];
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [OCC_W-1:0]      r_occ;
  logic                  r_inflight;
  logic                  w_credit;
  logic                  w_capture;
  logic                  w_pop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // A pop is only allowed when the buffer can hold it together with the word already in flight.
  assign w_credit  = ({1'b0, r_occ} + {{OCC_W{1'b0}}, r_inflight}) < {1'b0, FULL_OCC};
  // Held off during reset so no FIFO word is popped and then thrown away.
  assign bus.fifo_rd_en = !rst && en && !bus.fifo_empty && w_credit;

  assign w_capture   = r_inflight;
  assign bus.m_valid = (r_occ != '0);
  assign bus.m_data  = r_mem[r_head];
  assign w_pop       = bus.m_valid && bus.m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_head        <= '0;
      r_tail        <= '0;
      r_occ         <= '0;
      r_inflight    <= 1'b0;
      word_cnt      <= '0;
      err_underflow <= 1'b0;
    end else begin
      r_inflight <= bus.fifo_rd_en;
      if (w_capture) begin
        r_mem[r_tail] <= bus.fifo_data_out;
        r_tail        <= nextPtr(r_tail);
      end
      if (w_pop) begin
        r_head   <= nextPtr(r_head);
        word_cnt <= word_cnt + 1'b1;
      end
      case ({w_capture, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
      if (bus.fifo_underflow) begin
        err_underflow <= 1'b1;
      end
    end
  end

  // The credit rule makes a capture into a full buffer impossible; flag it if it ever happens.
  overrunCheck: assert property (@(posedge clk) disable iff (rst) !(w_capture && r_occ == FULL_OCC));
endmodule
